// File: rtl/multi_reg_seq.sv
// Load/store-multiple sequencer: moves a masked set of registers to or from
// consecutive memory words, with optional base-register writeback.
module multi_reg_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_dec,
  input  logic        i_wb,
  input  logic [3:0]  i_addr_rn,
  input  logic [31:0] i_base,
  input  logic [15:0] i_reg_list,
  output logic [3:0]  o_addr_rt,
  input  logic [31:0] i_rt_r,
  output logic [3:0]  o_addr_rd,
  output logic [31:0] o_rd,
  output logic        o_rd_wr_en,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_MEM  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_BWB  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [2:0]  state_r, state_s;
  logic        load_r, load_s;
  logic        wb_en_r, wb_en_s;
  logic [3:0]  rn_r, rn_s;
  logic [31:0] wb_val_r, wb_val_s;
  logic [15:0] mask_r, mask_s;
  logic [3:0]  cur_r, cur_s;
  logic [31:0] addr_r, addr_s;

  logic [4:0]  n_s;
  logic [31:0] offset_s;
  logic        more_s;
  logic [3:0]  next_cur_s;
  logic [2:0]  after_xfer_s;

  logic [3:0]  addr_rt_s, addr_rd_s;
  logic [31:0] rd_s;
  logic        rd_wr_en_s, mem_req_s, mem_we_s, busy_s, done_s;

  // Where to go once the current register's transfer is finished.
  always_comb begin
    more_s       = (mask_r != 16'd0);
    next_cur_s   = lowest_set(mask_r);
    after_xfer_s = ST_DONE;
    if (more_s) begin
      after_xfer_s = load_r ? ST_MEM : ST_RD;
    end else begin
      after_xfer_s = wb_en_r ? ST_BWB : ST_DONE;
    end
  end

  // Next-state and next-output computation; all outputs are registered from these.
  always_comb begin
    state_s  = state_r;
    load_s   = load_r;
    wb_en_s  = wb_en_r;
    rn_s     = rn_r;
    wb_val_s = wb_val_r;
    mask_s   = mask_r;
    cur_s    = cur_r;
    addr_s   = addr_r;
    n_s      = popcount16(i_reg_list);
    offset_s = {25'd0, n_s, 2'b00};

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          load_s   = i_load;
          rn_s     = i_addr_rn;
          // A loaded base register must keep the loaded value, so no writeback.
          wb_en_s  = i_wb & ~(i_load & i_reg_list[i_addr_rn]);
          wb_val_s = i_dec ? (i_base - offset_s) : (i_base + offset_s);
          addr_s   = i_dec ? (i_base - offset_s) : i_base;
          cur_s    = lowest_set(i_reg_list);
          mask_s   = i_reg_list & ~(16'd1 << lowest_set(i_reg_list));
          if (n_s == 5'd0) begin
            state_s = i_wb ? ST_BWB : ST_DONE;
          end else begin
            state_s = i_load ? ST_MEM : ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        state_s = ST_MEM;
      end
      ST_MEM: begin
        if (i_mem_ack && load_r) begin
          state_s = ST_WR;
        end else if (i_mem_ack) begin
          state_s = after_xfer_s;
          addr_s  = addr_r + 32'd4;
          cur_s   = more_s ? next_cur_s : cur_r;
          mask_s  = mask_r & ~(16'd1 << next_cur_s);
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WR: begin
        state_s = after_xfer_s;
        addr_s  = addr_r + 32'd4;
        cur_s   = more_s ? next_cur_s : cur_r;
        mask_s  = mask_r & ~(16'd1 << next_cur_s);
      end
      ST_BWB: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s     = (state_s != ST_IDLE);
    done_s     = (state_s == ST_DONE);
    mem_req_s  = (state_s == ST_MEM);
    mem_we_s   = (state_s == ST_MEM) & ~load_s;
    rd_wr_en_s = (state_s == ST_WR) | (state_s == ST_BWB);
    addr_rt_s  = (!load_s && (state_s == ST_RD || state_s == ST_MEM)) ? cur_s : 4'd0;
    addr_rd_s  = (state_s == ST_WR) ? cur_s : ((state_s == ST_BWB) ? rn_s : 4'd0);
    // WR is only entered from an acked MEM cycle, so the load data is on i_mem_rdata now.
    rd_s       = (state_s == ST_WR) ? i_mem_rdata : ((state_s == ST_BWB) ? wb_val_s : 32'd0);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      load_r      <= 1'b0;
      wb_en_r     <= 1'b0;
      rn_r        <= 4'd0;
      wb_val_r    <= 32'd0;
      mask_r      <= 16'd0;
      cur_r       <= 4'd0;
      addr_r      <= 32'd0;
      o_addr_rt   <= 4'd0;
      o_addr_rd   <= 4'd0;
      o_rd        <= 32'd0;
      o_rd_wr_en  <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_r     <= state_s;
      load_r      <= load_s;
      wb_en_r     <= wb_en_s;
      rn_r        <= rn_s;
      wb_val_r    <= wb_val_s;
      mask_r      <= mask_s;
      cur_r       <= cur_s;
      addr_r      <= addr_s;
      o_addr_rt   <= addr_rt_s;
      o_addr_rd   <= addr_rd_s;
      o_rd        <= rd_s;
      o_rd_wr_en  <= rd_wr_en_s;
      o_mem_req   <= mem_req_s;
      o_mem_we    <= mem_we_s;
      o_busy      <= busy_s;
      o_done      <= done_s;
    end
  end

  assign o_mem_addr  = addr_r;
  // Register-file read data only arrives during MEM, so store data is forwarded directly.
  assign o_mem_wdata = (state_r == ST_MEM && !load_r) ? i_rt_r : 32'd0;

endmodule

// File: tb/tb_multi_reg_seq.sv
// Scoreboard bench for multi_reg_seq: expected memory transfers and register
// writes are queued at launch and compared as the DUT produces them.
module tb_multi_reg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_load = 1'b0, i_dec = 1'b0, i_wb = 1'b0;
  logic [3:0]  i_addr_rn = 4'd0;
  logic [31:0] i_base = 32'd0;
  logic [15:0] i_reg_list = 16'd0;
  logic [3:0]  o_addr_rt, o_addr_rd;
  logic [31:0] i_rt_r = 32'd0;
  logic [31:0] o_rd, o_mem_addr, o_mem_wdata;
  logic        o_rd_wr_en, o_mem_req, o_mem_we, o_busy, o_done;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  multi_reg_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_load(i_load), .i_dec(i_dec), .i_wb(i_wb),
    .i_addr_rn(i_addr_rn), .i_base(i_base), .i_reg_list(i_reg_list),
    .o_addr_rt(o_addr_rt), .i_rt_r(i_rt_r), .o_addr_rd(o_addr_rd), .o_rd(o_rd),
    .o_rd_wr_en(o_rd_wr_en), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int ack_delay = 0, req_wait = 0, done_cnt = 0, done_before = 0;
  int edge_cnt = 0, launch_edge = 0, exp_lat = 0;
  logic [31:0] rf [16];
  logic [64:0] exp_mem_q [$];
  logic [35:0] exp_rf_q [$];
  logic [31:0] resp_q [$];
  logic [31:0] ld_src_q [$];
  logic [31:0] snap_addr, snap_wdata;
  logic        snap_we;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // registered-read register file model
  always @(posedge clk) i_rt_r <= rf[o_addr_rt];

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // memory responder and register-write scoreboard
  initial begin : monitor
    logic [64:0] e;
    logic [35:0] w;
    forever begin
      @(negedge clk);
      if (o_rd_wr_en) begin
        if (exp_rf_q.size() == 0) begin
          check_val("unexp_rf_wr", 32'(o_rd_wr_en), 32'd0);
        end else begin
          w = exp_rf_q.pop_front();
          check_val("rf_addr", 32'(o_addr_rd), 32'(w[35:32]));
          check_val("rf_data", o_rd, w[31:0]);
        end
      end
      if (o_done) done_cnt++;
      if (i_mem_ack) begin
        check_val("req_after_ack", 32'(o_mem_req), 32'd0);
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'd0;
        req_wait = 0;
      end else if (o_mem_req) begin
        if (req_wait == 0) begin
          snap_addr = o_mem_addr;
          snap_wdata = o_mem_wdata;
          snap_we = o_mem_we;
        end else begin
          check_val("hold_addr", o_mem_addr, snap_addr);
          check_val("hold_wdata", o_mem_wdata, snap_wdata);
          check_val("hold_we", 32'(o_mem_we), 32'(snap_we));
        end
        if (req_wait >= ack_delay) begin
          if (exp_mem_q.size() == 0) begin
            check_val("unexp_mem_req", 32'(o_mem_req), 32'd0);
          end else begin
            e = exp_mem_q.pop_front();
            check_val("mem_we", 32'(o_mem_we), 32'(e[64]));
            check_val("mem_addr", o_mem_addr, e[63:32]);
            if (e[64]) begin
              check_val("mem_wdata", o_mem_wdata, e[31:0]);
            end else if (resp_q.size() > 0) begin
              i_mem_rdata = resp_q.pop_front();
            end
          end
          i_mem_ack = 1'b1;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic launch(input logic ld, input logic dc, input logic wb, input logic [3:0] rn,
                        input logic [31:0] base, input logic [15:0] list);
    int n;
    logic [31:0] a, d;
    logic wbe;
    n = 0;
    for (int k = 0; k < 16; k++) if (list[k]) n++;
    a = dc ? base - 32'(4 * n) : base;
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        if (ld) begin
          if (ld_src_q.size() > 0) d = ld_src_q.pop_front();
          else d = $urandom();
          resp_q.push_back(d);
          exp_mem_q.push_back({1'b0, a, 32'd0});
          exp_rf_q.push_back({4'(k), d});
        end else begin
          exp_mem_q.push_back({1'b1, a, rf[k]});
        end
        a = a + 32'd4;
      end
    end
    wbe = wb && !(ld && list[rn]);
    if (wbe) exp_rf_q.push_back({rn, dc ? base - 32'(4 * n) : base + 32'(4 * n)});
    exp_lat = 2 + n * (2 + ack_delay) + (wbe ? 1 : 0);
    @(negedge clk);
    i_load = ld; i_dec = dc; i_wb = wb; i_addr_rn = rn; i_base = base; i_reg_list = list;
    i_start = 1'b1;
    launch_edge = edge_cnt;
    done_before = done_cnt;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_done) begin
        seen = 1'b1;
        check_val("latency", 32'(edge_cnt - launch_edge + 1), 32'(exp_lat));
        break;
      end
    end
    if (!seen) check_val("done_seen", 32'(o_done), 32'd1);
    repeat (3) tick();
    check_val("done_pulses", 32'(done_cnt - done_before), 32'd1);
    check_val("busy_after", 32'(o_busy), 32'd0);
    check_val("mem_q_left", 32'(exp_mem_q.size()), 32'd0);
    check_val("rf_q_left", 32'(exp_rf_q.size()), 32'd0);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_mem_req) break;
    end
    check_val("req_seen", 32'(o_mem_req), 32'd1);
    check_val("busy_in_seq", 32'(o_busy), 32'd1);
  endtask

  task automatic check_idle();
    check_val("idle_busy", 32'(o_busy), 32'd0);
    check_val("idle_done", 32'(o_done), 32'd0);
    check_val("idle_req", 32'(o_mem_req), 32'd0);
    check_val("idle_we", 32'(o_mem_we), 32'd0);
    check_val("idle_wr_en", 32'(o_rd_wr_en), 32'd0);
    check_val("idle_maddr", o_mem_addr, 32'd0);
    check_val("idle_wdata", o_mem_wdata, 32'd0);
    check_val("idle_rd", o_rd, 32'd0);
    check_val("idle_rt", 32'(o_addr_rt), 32'd0);
    check_val("idle_rdaddr", 32'(o_addr_rd), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) rf[k] = 32'h1111_0000 + 32'(k) * 32'h0101;
    repeat (3) tick();
    rst = 1'b0;
    check_idle();

    // store IA with writeback
    ack_delay = 0;
    launch(1'b0, 1'b0, 1'b1, 4'd13, 32'h0000_0100, 16'h0006);
    wait_done(50);

    // load DB, no writeback
    ld_src_q.push_back(32'h0000_AAAA);
    ld_src_q.push_back(32'h0000_BBBB);
    launch(1'b1, 1'b1, 1'b0, 4'd2, 32'h0000_0200, 16'h8001);
    wait_done(50);

    // load with base register in list: writeback suppressed
    ld_src_q.push_back(32'h3333_CAFE);
    launch(1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_0300, 16'h0008);
    wait_done(50);

    // empty list with writeback
    launch(1'b0, 1'b0, 1'b1, 4'd7, 32'h0000_0040, 16'h0000);
    wait_done(50);

    // delayed ack and a start pulse while busy
    ack_delay = 3;
    launch(1'b0, 1'b0, 1'b0, 4'd1, 32'h0000_0500, 16'h0011);
    wait_req(20);
    i_start = 1'b1; i_load = 1'b1; i_reg_list = 16'hFFFF; i_base = 32'h0000_9000;
    wait_done(100);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("not_queued", 32'(o_busy), 32'd0);
    end

    // reset mid-sequence while waiting for ack; start coincides with reset
    ack_delay = 50;
    launch(1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_0600, 16'h00F0);
    wait_req(20);
    repeat (2) tick();
    rst = 1'b1;
    i_start = 1'b1;
    tick();
    exp_mem_q.delete();
    exp_rf_q.delete();
    resp_q.delete();
    rst = 1'b0;
    check_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("post_rst_idle", 32'(o_busy), 32'd0);
    end
    ack_delay = 0;

    // store DB across address zero
    launch(1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_0004, 16'h0003);
    wait_done(50);

    // load IA of a sparse list with writeback
    launch(1'b1, 1'b0, 1'b1, 4'd5, 32'h0000_1000, 16'h8421);
    wait_done(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
